mult32x32_io_ctrl: RTL and testbench

//  Handshake front/back end for the 32x32 sequential multiplier core.
//  - Accepts operand pairs on a valid/ready input channel.
//  - Holds the operands stable, issues a one-cycle start to the core and tracks its busy envelope.
//  - Captures the 64-bit product and presents it on a valid/ready output channel.
//  - Flags a sticky error when the core does not respond within a bounded number of cycles.

---
 rtl/mult32x32_io_ctrl.sv | 153 +++++++++++++++
 tb/tb_mult32x32_io_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_io_ctrl.sv
// Valid/ready wrapper around the 32x32 sequential multiplier core: issues a start pulse,
// tracks the core's busy envelope, captures the product and flags a sticky timeout error.
module mult32x32_io_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  output logic [31:0]      mult_a_o,
  output logic [31:0]      mult_b_o,
  output logic             mult_start_o,
  input  logic             mult_busy_i,
  input  logic [63:0]      mult_product_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_product_o,
  output logic             err_o,
  input  logic             clr_err_i,
  output logic [CNT_W-1:0] op_count_o
);

  localparam int unsigned WaitW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StRun, StHold, StErr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             rdy_q, rdy_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [63:0]      prod_q, prod_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rdy_d   = rdy_q;
    start_d = 1'b0;
    valid_d = valid_q;
    err_d   = err_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        rdy_d = 1'b1;
        if (in_valid_i && rdy_q) begin
          a_d     = in_a_i;
          b_d     = in_b_i;
          start_d = 1'b1;
          rdy_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_d  = '0;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (mult_busy_i) begin
          wait_d  = '0;
          state_d = StRun;
        end else if (wait_q == WaitMax) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRun: begin
        if (!mult_busy_i) begin
          prod_d  = mult_product_i;
          valid_d = 1'b1;
          state_d = StHold;
        end else if (wait_q == WaitMax) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          count_d = count_q + 1'b1;
          valid_d = 1'b0;
          // Handshake and new operands in the same cycle skip IDLE entirely.
          if (in_valid_i) begin
            a_d     = in_a_i;
            b_d     = in_b_i;
            start_d = 1'b1;
            state_d = StIssue;
          end else begin
            rdy_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StErr: begin
        if (clr_err_i) begin
          err_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      wait_q  <= '0;
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  // rdy_q is low throughout reset, so every output reads 0 while rst_ni is low.
  assign in_ready_o    = rdy_q | ((state_q == StHold) & out_ready_i);
  assign mult_a_o      = a_q;
  assign mult_b_o      = b_q;
  assign mult_start_o  = start_q;
  assign out_valid_o   = valid_q;
  assign out_product_o = prod_q;
  assign err_o         = err_q;
  assign op_count_o    = count_q;

endmodule

// File: tb/tb_mult32x32_io_ctrl.sv
// Bench for mult32x32_io_ctrl: behavioural core (one load cycle, 8 busy cycles) plus a
// reference of products, latency, timeout and delivered-result count.
module tb_mult32x32_io_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int          LATENCY = 11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [31:0]      in_a = '0, in_b = '0, mult_a, mult_b;
  logic             mult_start, mult_busy;
  logic [63:0]      mult_product;
  logic             out_valid, out_ready = 1'b0;
  logic [63:0]      out_product;
  logic             err, clr_err = 1'b0;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  bit core_dead = 1'b0;

  always #5 clk = ~clk;

  mult32x32_io_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
    .mult_a_o(mult_a), .mult_b_o(mult_b), .mult_start_o(mult_start),
    .mult_busy_i(mult_busy), .mult_product_i(mult_product),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_product_o(out_product),
    .err_o(err), .clr_err_i(clr_err), .op_count_o(op_count)
  );

  // Core model: samples start, spends one load cycle, then is busy for 8 cycles; the
  // product register only becomes correct as busy falls.
  logic       pend;
  logic [3:0] left;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; mult_busy <= 1'b0; left <= '0; mult_product <= '0;
    end else if (mult_start && !core_dead) begin
      pend <= 1'b1; mult_product <= 64'hDEAD_BEEF_0BAD_F00D;
    end else if (pend) begin
      pend <= 1'b0; mult_busy <= 1'b1; left <= 4'd8;
    end else if (mult_busy) begin
      if (left == 4'd1) begin
        mult_busy <= 1'b0;
        mult_product <= 64'(mult_a) * 64'(mult_b);
      end
      left <= left - 4'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Caller is #1 after a rising edge with out_ready low.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int bp);
    int w;
    int n;
    logic [63:0] expp;
    expp = 64'(a) * 64'(b);
    in_valid = 1'b1; in_a = a; in_b = b;
    w = 0;
    while (!in_ready && w < 30) begin @(posedge clk); #1; w++; end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    check("start_pulse", {63'd0, mult_start}, 64'd1);
    check("latched_a", {32'd0, mult_a}, {32'd0, a});
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1; n++;
      if (n == 1) check("start_one_cycle", {63'd0, mult_start}, 64'd0);
    end
    check("latency", 64'(n), 64'(LATENCY));
    check("product", out_product, expp);
    check("held_b", {32'd0, mult_b}, {32'd0, b});
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_product", out_product, expp);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1 check("hold_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt++;
    check("valid_drop", {63'd0, out_valid}, 64'd0);
    check("op_count", 64'(op_count), 64'(CNT_W'(exp_cnt)));
  endtask

  initial begin
    logic [63:0] expq[$];
    logic [31:0] ra, rb;
    int n, acc_n, done_n, cyc;
    bit acc, hs;

    // Reset values
    #3;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_start_err", {62'd0, mult_start, err}, 64'd0);
    check("rst_a_b", {mult_a, mult_b}, 64'd0);
    check("rst_product", out_product, 64'd0);
    check("rst_count", 64'(op_count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {63'd0, in_ready}, 64'd1);

    // Directed and max operands, then backpressure
    run_op(32'd3, 32'd5, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("max_product", out_product, 64'hFFFF_FFFE_0000_0001);
    run_op($urandom, $urandom, 5);
    for (int k = 0; k < 4; k++) run_op($urandom, $urandom, int'($urandom_range(0, 3)));

    // clr_err outside ERR is ignored
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    check("clr_ignored", {62'd0, err, in_ready}, 64'd1);

    // Back-to-back: in_valid held, out_ready high
    out_ready = 1'b1;
    ra = $urandom; rb = $urandom;
    in_valid = 1'b1; in_a = ra; in_b = rb;
    acc_n = 0; done_n = 0; cyc = 0;
    while (done_n < 4 && cyc < 200) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (mult_start) check("start_not_busy", {63'd0, mult_busy}, 64'd0);
      @(posedge clk); #1; cyc++;
      if (hs) begin
        exp_cnt++; done_n++;
        check("b2b_product_vs_queue", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) void'(expq.pop_front());
        check("b2b_count", 64'(op_count), 64'(CNT_W'(exp_cnt)));
        if (acc) check("b2b_issue", {63'd0, mult_start}, 64'd1);
      end
      if (acc) begin
        expq.push_back(64'(ra) * 64'(rb));
        acc_n++;
        if (acc_n < 4) begin ra = $urandom; rb = $urandom; in_a = ra; in_b = rb; end
        else in_valid = 1'b0;
      end
      if (out_valid && expq.size() > 0) check("b2b_product", out_product, expq[0]);
    end
    check("b2b_done", 64'(done_n), 64'd4);
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Timeout: core ignores start
    core_dead = 1'b1;
    in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (!err && n < 60) begin @(posedge clk); #1; n++; end
    check("timeout_edges", 64'(n), 64'(TIMEOUT + 1));
    repeat (3) @(posedge clk); #1;
    check("err_sticky", {63'd0, err}, 64'd1);
    check("err_outputs", {61'd0, in_ready, out_valid, mult_start}, 64'd0);
    check("err_keeps_a", {32'd0, mult_a}, 64'h1234_5678);
    clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    check("err_cleared", {62'd0, err, in_ready}, 64'd1);
    check("err_count", 64'(op_count), 64'(CNT_W'(exp_cnt)));
    core_dead = 1'b0;

    // Async reset while the core is running
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {59'd0, in_ready, out_valid, mult_start, err, |out_product}, 64'd0);
    check("arst_ops", {mult_a | mult_b, 16'd0, op_count}, 64'd0);
    exp_cnt = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op($urandom, $urandom, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog expired observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
